// File: rtl/pokey_pot_scan_ctrl.sv
//==============================================================================
// Module  : pokey_pot_scan_ctrl
// Brief   : POKEY paddle scan sequencer: dump, release, line count, per-pot latch.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module pokey_pot_scan_ctrl #(
    parameter int NUM_POTS   = 2,
    parameter int POT_MAX    = 228,
    parameter int DUMP_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    tick_15k,
    input  logic                    fast_scan,
    input  logic                    potgo_strobe,
    input  logic [NUM_POTS-1:0]     pot_in,
    output logic [NUM_POTS-1:0]     pot_rel,
    output logic [8*NUM_POTS-1:0]   pot_val,
    output logic [7:0]              allpot,
    output logic [7:0]              bin_ctr,
    output logic                    busy,
    output logic                    scan_done
);

    localparam int              DW          = (DUMP_TICKS < 2) ? 1 : $clog2(DUMP_TICKS);
    localparam logic [DW-1:0]   C_DUMP_LAST = DW'(DUMP_TICKS - 1);
    localparam logic [7:0]      C_POT_MAX   = 8'(POT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [DW-1:0]                  dump_cnt_q, dump_cnt_d;
    logic [NUM_POTS-1:0]            sync1_q, pot_s_q;
    logic [NUM_POTS-1:0]            pot_rel_q, pot_rel_d;
    logic [NUM_POTS-1:0][7:0]       pot_val_q, pot_val_d;
    logic [NUM_POTS-1:0]            allpot_q, allpot_d;
    logic [7:0]                     bin_ctr_q, bin_ctr_d;
    logic                           done_q, done_d;

    logic                           ce;
    logic [NUM_POTS-1:0]            trip;
    logic [NUM_POTS-1:0]            remain;

    assign ce     = fast_scan | tick_15k;
    assign trip   = allpot_q & pot_s_q;
    assign remain = allpot_q & ~trip;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            dump_cnt_q <= '0;
            sync1_q    <= '0;
            pot_s_q    <= '0;
            pot_rel_q  <= '1;
            pot_val_q  <= '0;
            allpot_q   <= '0;
            bin_ctr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dump_cnt_q <= dump_cnt_d;
            sync1_q    <= pot_in;
            pot_s_q    <= sync1_q;
            pot_rel_q  <= pot_rel_d;
            pot_val_q  <= pot_val_d;
            allpot_q   <= allpot_d;
            bin_ctr_q  <= bin_ctr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dump_cnt_d = dump_cnt_q;
        pot_rel_d  = pot_rel_q;
        pot_val_d  = pot_val_q;
        allpot_d   = allpot_q;
        bin_ctr_d  = bin_ctr_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pot_rel_d = '1;
                if (potgo_strobe) begin
                    state_d    = ST_DUMP;
                    dump_cnt_d = '0;
                end
            end
            ST_DUMP: begin
                // A POTGO write always wins over a coincident count enable.
                if (potgo_strobe) begin
                    dump_cnt_d = '0;
                end else if (ce) begin
                    if (dump_cnt_q == C_DUMP_LAST) begin
                        state_d    = ST_SCAN;
                        dump_cnt_d = '0;
                        bin_ctr_d  = '0;
                        pot_rel_d  = '0;
                        allpot_d   = '1;
                    end else begin
                        dump_cnt_d = dump_cnt_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (potgo_strobe) begin
                    state_d    = ST_DUMP;
                    dump_cnt_d = '0;
                    pot_rel_d  = '1;
                    allpot_d   = '0;
                end else if (ce) begin
                    for (int i = 0; i < NUM_POTS; i++) begin
                        if (trip[i]) pot_val_d[i] = bin_ctr_q;
                    end
                    allpot_d  = remain;
                    pot_rel_d = pot_rel_q | trip;
                    if ((bin_ctr_q == C_POT_MAX) || (remain == '0)) begin
                        // Pots still untripped at the end are forced to full scale.
                        for (int i = 0; i < NUM_POTS; i++) begin
                            if (remain[i]) pot_val_d[i] = C_POT_MAX;
                        end
                        allpot_d  = '0;
                        pot_rel_d = '1;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bin_ctr_d = bin_ctr_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        allpot                 = '0;
        allpot[NUM_POTS-1:0]   = allpot_q;
    end

    assign pot_rel   = pot_rel_q;
    assign pot_val   = pot_val_q;
    assign bin_ctr   = bin_ctr_q;
    assign busy      = (state_q != ST_IDLE);
    assign scan_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pokey_pot_scan_ctrl.sv
//==============================================================================
// Module  : tb_pokey_pot_scan_ctrl
// Brief   : Self-checking bench for pokey_pot_scan_ctrl with a per-scan reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pokey_pot_scan_ctrl;

    localparam int NUM_POTS   = 2;
    localparam int POT_MAX    = 228;
    localparam int D          = 2;
    localparam int NEVER      = 300;
    localparam int RUN_LIMIT  = 20000;

    logic                   clk;
    logic                   n_reset;
    logic                   tick_15k;
    logic                   fast_scan;
    logic                   potgo_strobe;
    logic [NUM_POTS-1:0]    pot_in;
    logic [NUM_POTS-1:0]    pot_rel;
    logic [8*NUM_POTS-1:0]  pot_val;
    logic [7:0]             allpot;
    logic [7:0]             bin_ctr;
    logic                   busy;
    logic                   scan_done;

    pokey_pot_scan_ctrl #(
        .NUM_POTS   (NUM_POTS),
        .POT_MAX    (POT_MAX),
        .DUMP_TICKS (D)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .tick_15k     (tick_15k),
        .fast_scan    (fast_scan),
        .potgo_strobe (potgo_strobe),
        .pot_in       (pot_in),
        .pot_rel      (pot_rel),
        .pot_val      (pot_val),
        .allpot       (allpot),
        .bin_ctr      (bin_ctr),
        .busy         (busy),
        .scan_done    (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         period = 1800;
    int         tcnt   = 0;
    logic [7:0] exp_val [NUM_POTS];
    logic [7:0] exp_bin;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line-rate enable for the edge that follows.
    task automatic next_tick();
        tcnt++;
        tick_15k = ((tcnt % period) == 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rel"},  16'(pot_rel), 16'h3);
        chk({tag, "_all"},  16'(allpot), 16'h0);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
        chk({tag, "_done"}, 16'(scan_done), 16'h0);
        chk({tag, "_bin"},  16'(bin_ctr), 16'(exp_bin));
        chk({tag, "_val"},  pot_val, {exp_val[1], exp_val[0]});
    endtask

    // Edge index (counted in ce since POTGO) after which pot_in must rise so the
    // synchronised value is first seen on scan line t.
    function automatic int raise_n(input int t);
        if (fast_scan) return t + D - 2;
        return (t == 0) ? D - 1 : t + D;
    endfunction

    // One scan: t0/t1 are the lines at which each pot trips (NEVER = no trip).
    // abort_n >= 0 returns after that ce count so the next POTGO aborts the scan;
    // restrobe_n >= 0 repeats POTGO once when that ce count is reached.
    task automatic run_scan(input int t0, input int t1, input int abort_n,
                            input int restrobe_n, input string nm);
        int t [NUM_POTS];
        int e, n, k, cyc;
        bit restrobed, fin, ce_now, sb_now;
        logic [7:0] ea;
        logic [1:0] er;
        logic       eb;
        t[0] = t0;
        t[1] = t1;
        e = (t0 > t1) ? t0 : t1;
        if (e > POT_MAX) e = POT_MAX;
        restrobed = 1'b0;
        fin = 1'b0;
        cyc = 0;
        for (int i = 0; i < NUM_POTS; i++) pot_in[i] = (-1 >= raise_n(t[i]));
        potgo_strobe = 1'b1;
        next_tick();
        @(posedge clk); #1;
        potgo_strobe = 1'b0;
        n = 0;
        forever begin
            ea = 8'h00;
            er = 2'b11;
            eb = 1'b1;
            if (n == D) begin
                ea = 8'h03;
                er = 2'b00;
                exp_bin = 8'h00;
            end else if (n > D) begin
                k = n - D - 1;
                for (int i = 0; i < NUM_POTS; i++) if (t[i] == k) exp_val[i] = 8'(k);
                if (k < e) begin
                    for (int i = 0; i < NUM_POTS; i++) if (t[i] > k) ea[i] = 1'b1;
                    er = ~ea[1:0];
                    exp_bin = 8'(k + 1);
                end else begin
                    for (int i = 0; i < NUM_POTS; i++) if (t[i] > k) exp_val[i] = 8'(POT_MAX);
                    eb = 1'b0;
                    exp_bin = 8'(e);
                end
            end
            chk({nm, "_allpot"},  16'(allpot), 16'(ea));
            chk({nm, "_pot_rel"}, 16'(pot_rel), 16'(er));
            chk({nm, "_busy"},    16'(busy), 16'(eb));
            chk({nm, "_done"},    16'(scan_done), 16'(fin));
            chk({nm, "_bin"},     16'(bin_ctr), 16'(exp_bin));
            chk({nm, "_pot_val"}, pot_val, {exp_val[1], exp_val[0]});
            if (fin) begin
                next_tick();
                @(posedge clk); #1;
                chk({nm, "_done_pulse"}, 16'(scan_done), 16'h0);
                chk({nm, "_idle_busy"}, 16'(busy), 16'h0);
                return;
            end
            if (n == abort_n) return;
            if (cyc > RUN_LIMIT) begin
                checks++;
                errors++;
                $error("FAIL %s_timeout observed=%0d expected=%0d", nm, cyc, RUN_LIMIT);
                return;
            end
            for (int i = 0; i < NUM_POTS; i++) pot_in[i] = (n >= raise_n(t[i]));
            sb_now = (!restrobed && n == restrobe_n);
            potgo_strobe = sb_now;
            next_tick();
            ce_now = fast_scan || tick_15k;
            @(posedge clk); #1;
            potgo_strobe = 1'b0;
            cyc++;
            if (sb_now) begin
                n = 0;
                restrobed = 1'b1;
            end else if (ce_now) begin
                n++;
            end
            fin = ce_now && !sb_now && (n == D + 1 + e);
        end
    endtask

    initial begin
        n_reset = 1'b0;
        tick_15k = 1'b0;
        fast_scan = 1'b1;
        potgo_strobe = 1'b0;
        pot_in = '0;
        exp_bin = 8'h00;
        for (int i = 0; i < NUM_POTS; i++) exp_val[i] = 8'h00;

        // Reset with pot_in toggling, then idle hold after release.
        repeat (3) begin @(posedge clk); #1; pot_in = ~pot_in; end
        chk_idle("reset");
        n_reset = 1'b1;
        repeat (4) begin @(posedge clk); #1; chk_idle("post_reset"); pot_in = 2'($urandom); end
        pot_in = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset asserted in the middle of a scan.
        run_scan(10, NEVER, 40, -1, "pre_rst");
        #2 n_reset = 1'b0;
        #1;
        exp_bin = 8'h00;
        for (int i = 0; i < NUM_POTS; i++) exp_val[i] = 8'h00;
        chk_idle("mid_reset");
        @(posedge clk); #1;
        n_reset = 1'b1;
        repeat (5) begin @(posedge clk); #1; chk_idle("hold"); pot_in = 2'($urandom); end
        pot_in = '0;
        repeat (3) @(posedge clk);
        #1;

        // Pot 0 trips at line 50, pot 1 never trips.
        run_scan(50, NEVER, -1, -1, "fast50");

        // Abort at bin_ctr=100 after pot 0 latched 30, then rescan tripping at 70.
        run_scan(30, NEVER, D + 1 + 99, -1, "abort");
        run_scan(70, NEVER, -1, -1, "rescan");

        // POTGO coinciding with the dump-terminal count enable.
        run_scan(20, 35, -1, D - 1, "restrobe");

        // No pot ever trips: full-length scan.
        run_scan(NEVER, NEVER, -1, -1, "full");

        // Both pots trip on the same line.
        run_scan(17, 17, -1, -1, "same");

        for (int r = 0; r < 5; r++) begin
            run_scan(int'($urandom_range(0, 240)), int'($urandom_range(0, 240)), -1, -1, "rnd_fast");
        end

        // Line-rate scanning: both pots tripped before release.
        fast_scan = 1'b0;
        period = 1800;
        run_scan(0, 0, -1, -1, "slow0");

        period = 9;
        for (int r = 0; r < 3; r++) begin
            run_scan(int'($urandom_range(0, 30)), int'($urandom_range(0, 30)), -1, -1, "rnd_slow");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
